dmem_port_ctrl: RTL and testbench

- Sequencer and arbiter for the data port of the unified instruction/data memory. The memory has a synchronous read with 1-cycle latency and word-wide writes only.
- Shares that port between the CPU core's load/store unit and a program loader (word writes only).
- Converts CPU byte and halfword stores into read-modify-write sequences.
- Extracts sub-word load data for the CPU.
- The instruction port is not touched by this block.

---
 rtl/dmem_port_ctrl.sv | 153 +++++++++++++++
 tb/tb_dmem_port_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_ctrl.sv
// Data-port sequencer/arbiter for the unified memory: shares the port between
// the CPU load/store unit and the program loader, and does sub-word RMW/extract.
module dmem_port_ctrl #(
  parameter int WORD_LEN    = 32,
  parameter bit LD_PRIORITY = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [1:0]          cpu_size,
  input  logic [WORD_LEN-1:0] cpu_addr,
  input  logic [WORD_LEN-1:0] cpu_wdata,
  output logic                cpu_ready,
  output logic [WORD_LEN-1:0] cpu_rdata,
  input  logic                ld_req,
  input  logic [WORD_LEN-1:0] ld_addr,
  input  logic [WORD_LEN-1:0] ld_wdata,
  output logic                ld_ack,
  output logic [WORD_LEN-1:0] mem_addr,
  output logic                mem_wen,
  output logic [WORD_LEN-1:0] mem_wdata,
  input  logic [WORD_LEN-1:0] mem_rdata
);

  // state | meaning
  // IDLE  | arbitrate; word writes issue here, reads of target word start here
  // RD    | capture and align load data from memory
  // RMW   | write back read word with the store lane merged in
  // RESP  | one-cycle completion pulse to the latched owner
  typedef enum logic [1:0] {IDLE, RD, RMW, RESP} state_t;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;  // 1 = loader
  logic                we_q, we_d;
  logic [1:0]          size_q, size_d;
  logic [WORD_LEN-1:0] addr_q, addr_d;
  logic [WORD_LEN-1:0] wdata_q, wdata_d;
  logic [WORD_LEN-1:0] rdata_q, rdata_d;

  logic                grant_ld, grant_cpu;
  logic [4:0]          lane_sh;
  logic [WORD_LEN-1:0] lane_mask;
  logic [WORD_LEN-1:0] rd_extract, rmw_merge;

  always_comb begin
    lane_sh   = 5'd0;
    lane_mask = '1;
    if (size_q == 2'b00) begin
      lane_sh   = {addr_q[1:0], 3'b000};
      lane_mask = WORD_LEN'(8'hFF);
    end else if (size_q == 2'b01) begin
      lane_sh   = {addr_q[1], 4'b0000};
      lane_mask = WORD_LEN'(16'hFFFF);
    end
    rd_extract = (mem_rdata >> lane_sh) & lane_mask;
    rmw_merge  = (mem_rdata & ~(lane_mask << lane_sh)) | ((wdata_q & lane_mask) << lane_sh);
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    we_d      = we_q;
    size_d    = size_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    mem_addr  = addr_q;
    mem_wen   = 1'b0;
    mem_wdata = wdata_q;
    cpu_ready = 1'b0;
    ld_ack    = 1'b0;
    grant_ld  = ld_req && (!cpu_req || LD_PRIORITY);
    grant_cpu = cpu_req && !grant_ld;

    case (state_q)
      IDLE: begin
        if (grant_ld) begin
          owner_d   = 1'b1;
          we_d      = 1'b1;
          size_d    = 2'b10;
          addr_d    = ld_addr;
          wdata_d   = ld_wdata;
          mem_addr  = ld_addr;
          mem_wen   = 1'b1;
          mem_wdata = ld_wdata;
          state_d   = RESP;
        end else if (grant_cpu) begin
          owner_d   = 1'b0;
          we_d      = cpu_we;
          size_d    = cpu_size;
          addr_d    = cpu_addr;
          wdata_d   = cpu_wdata;
          mem_addr  = cpu_addr;
          mem_wdata = cpu_wdata;
          if (cpu_we && cpu_size[1]) begin
            mem_wen = 1'b1;
            state_d = RESP;
          end else if (cpu_we) begin
            state_d = RMW;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: begin
        rdata_d = rd_extract;
        state_d = RESP;
      end
      RMW: begin
        mem_wen   = 1'b1;
        mem_wdata = rmw_merge;
        state_d   = RESP;
      end
      RESP: begin
        cpu_ready = !owner_q;
        ld_ack    = owner_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // an access caught by reset must never reach the array or complete
    if (rst) begin
      mem_wen   = 1'b0;
      cpu_ready = 1'b0;
      ld_ack    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign cpu_rdata = rdata_q;

endmodule

// File: tb/tb_dmem_port_ctrl.sv
// Directed bench for dmem_port_ctrl with a behavioural 1-cycle-latency memory
// per instance; the second instance runs with CPU tie-break priority.
module tb_dmem_port_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  int          n_checks = 0;
  int          n_errors = 0;

  // instance A: loader priority
  logic        cpu_req, cpu_we, cpu_ready, ld_req, ld_ack, mem_wen;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, ld_addr, ld_wdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] mem_a [64];

  // instance B: CPU priority
  logic        cpu_req_b, cpu_ready_b, ld_req_b, ld_ack_b, mem_wen_b;
  logic [31:0] cpu_rdata_b, mem_addr_b, mem_wdata_b, mem_rdata_b;
  logic [31:0] mem_b [64];

  always #5 clk = ~clk;

  dmem_port_ctrl #(.WORD_LEN(32), .LD_PRIORITY(1'b1)) u_dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ack(ld_ack),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  dmem_port_ctrl #(.WORD_LEN(32), .LD_PRIORITY(1'b0)) u_dut_b (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req_b), .cpu_we(1'b0), .cpu_size(2'b10),
    .cpu_addr(32'h40), .cpu_wdata(32'h0),
    .cpu_ready(cpu_ready_b), .cpu_rdata(cpu_rdata_b),
    .ld_req(ld_req_b), .ld_addr(32'h80), .ld_wdata(32'hDEADBEEF), .ld_ack(ld_ack_b),
    .mem_addr(mem_addr_b), .mem_wen(mem_wen_b), .mem_wdata(mem_wdata_b),
    .mem_rdata(mem_rdata_b)
  );

  always @(posedge clk) begin
    if (mem_wen) mem_a[mem_addr[7:2]] <= mem_wdata;
    mem_rdata <= mem_a[mem_addr[7:2]];
    if (mem_wen_b) mem_b[mem_addr_b[7:2]] <= mem_wdata_b;
    mem_rdata_b <= mem_b[mem_addr_b[7:2]];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // full CPU access on instance A; returns data and cycles from accept to ready
  task automatic cpu_op(input logic we, input logic [1:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata, output int lat);
    bit seen = 0;
    cpu_req = 1'b1; cpu_we = we; cpu_size = size; cpu_addr = addr; cpu_wdata = wdata;
    lat = 0;
    rdata = '0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (cpu_ready) begin
        seen  = 1;
        rdata = cpu_rdata;
        cpu_req = 1'b0;
      end else begin
        lat++;
      end
      next_cyc();
    end
    if (!seen) chk("cpu_op_timeout", 32'd0, 32'd1);
  endtask

  logic [31:0] rd;
  int          lat;

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem_a[i] = 32'h0;
      mem_b[i] = 32'h0;
    end
    mem_a[6'h10] = 32'h11223344;
    mem_b[6'h10] = 32'h11223344;
    rst = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_size = 2'b10; cpu_addr = 0; cpu_wdata = 0;
    ld_req = 0; ld_addr = 0; ld_wdata = 0;
    cpu_req_b = 0; ld_req_b = 0;
    next_cyc();
    next_cyc();
    rst = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_ready", {31'b0, cpu_ready}, 32'd0);
    chk("rst_ack", {31'b0, ld_ack}, 32'd0);
    chk("rst_rdata", cpu_rdata, 32'h0);
    chk("rst_wen", {31'b0, mem_wen}, 32'd0);
    chk("rst_addr", mem_addr, 32'h0);
    next_cyc();

    // 1: word load
    cpu_req = 1; cpu_we = 0; cpu_size = 2'b10; cpu_addr = 32'h40;
    @(negedge clk);
    chk("t1_T_wen", {31'b0, mem_wen}, 32'd0);
    chk("t1_T_addr", mem_addr, 32'h40);
    chk("t1_T_ready", {31'b0, cpu_ready}, 32'd0);
    next_cyc(); @(negedge clk);
    chk("t1_T1_wen", {31'b0, mem_wen}, 32'd0);
    chk("t1_T1_ready", {31'b0, cpu_ready}, 32'd0);
    next_cyc(); @(negedge clk);
    chk("t1_T2_ready", {31'b0, cpu_ready}, 32'd1);
    chk("t1_T2_wen", {31'b0, mem_wen}, 32'd0);
    chk("t1_rdata", cpu_rdata, 32'h11223344);
    cpu_req = 0;
    next_cyc(); @(negedge clk);
    chk("t1_T3_ready", {31'b0, cpu_ready}, 32'd0);
    chk("t1_hold_rdata", cpu_rdata, 32'h11223344);
    next_cyc();

    // 2: byte store via RMW
    cpu_req = 1; cpu_we = 1; cpu_size = 2'b00; cpu_addr = 32'h42; cpu_wdata = 32'h000000AA;
    @(negedge clk);
    chk("t2_T_wen", {31'b0, mem_wen}, 32'd0);
    chk("t2_T_addr", mem_addr, 32'h42);
    next_cyc(); @(negedge clk);
    chk("t2_T1_wen", {31'b0, mem_wen}, 32'd1);
    chk("t2_T1_wdata", mem_wdata, 32'h11AA3344);
    chk("t2_T1_ready", {31'b0, cpu_ready}, 32'd0);
    next_cyc(); @(negedge clk);
    chk("t2_T2_ready", {31'b0, cpu_ready}, 32'd1);
    chk("t2_T2_wen", {31'b0, mem_wen}, 32'd0);
    cpu_req = 0;
    next_cyc();
    cpu_op(1'b0, 2'b10, 32'h40, 32'h0, rd, lat);
    chk("t2_reload", rd, 32'h11AA3344);
    chk("t2_reload_lat", lat, 32'd2);

    // restore word with a word store (1-cycle completion)
    cpu_op(1'b1, 2'b10, 32'h40, 32'h11223344, rd, lat);
    chk("restore_lat", lat, 32'd1);
    chk("restore_mem", mem_a[6'h10], 32'h11223344);

    // 3: sub-word loads
    cpu_op(1'b0, 2'b01, 32'h42, 32'h0, rd, lat);
    chk("t3_half42", rd, 32'h00001122);
    cpu_op(1'b0, 2'b00, 32'h41, 32'h0, rd, lat);
    chk("t3_byte41", rd, 32'h00000033);
    cpu_op(1'b0, 2'b00, 32'h43, 32'h0, rd, lat);
    chk("t3_byte43", rd, 32'h00000011);
    cpu_op(1'b0, 2'b01, 32'h41, 32'h0, rd, lat);
    chk("t3_half41", rd, 32'h00003344);
    cpu_op(1'b1, 2'b01, 32'h40, 32'h0000BEEF, rd, lat);
    chk("half_store_lat", lat, 32'd2);
    chk("half_store_mem", mem_a[6'h10], 32'h1122BEEF);
    cpu_op(1'b1, 2'b10, 32'h40, 32'h11223344, rd, lat);

    // 4: simultaneous requests, loader priority
    ld_req = 1; ld_addr = 32'h80; ld_wdata = 32'hDEADBEEF;
    cpu_req = 1; cpu_we = 0; cpu_size = 2'b10; cpu_addr = 32'h40;
    @(negedge clk);
    chk("t4_T_wen", {31'b0, mem_wen}, 32'd1);
    chk("t4_T_addr", mem_addr, 32'h80);
    chk("t4_T_wdata", mem_wdata, 32'hDEADBEEF);
    next_cyc(); @(negedge clk);
    chk("t4_T1_ack", {31'b0, ld_ack}, 32'd1);
    chk("t4_T1_ready", {31'b0, cpu_ready}, 32'd0);
    ld_req = 0;
    next_cyc(); @(negedge clk);
    chk("t4_T2_addr", mem_addr, 32'h40);
    chk("t4_T2_ack", {31'b0, ld_ack}, 32'd0);
    next_cyc(); @(negedge clk);
    chk("t4_T3_ready", {31'b0, cpu_ready}, 32'd0);
    next_cyc(); @(negedge clk);
    chk("t4_T4_ready", {31'b0, cpu_ready}, 32'd1);
    chk("t4_rdata", cpu_rdata, 32'h11223344);
    cpu_req = 0;
    next_cyc();
    chk("t4_ld_mem", mem_a[6'h20], 32'hDEADBEEF);

    // 4b: same contest with CPU priority
    ld_req_b = 1; cpu_req_b = 1;
    @(negedge clk);
    chk("t4b_T_wen", {31'b0, mem_wen_b}, 32'd0);
    chk("t4b_T_addr", mem_addr_b, 32'h40);
    next_cyc(); @(negedge clk);
    chk("t4b_T1_ack", {31'b0, ld_ack_b}, 32'd0);
    next_cyc(); @(negedge clk);
    chk("t4b_T2_ready", {31'b0, cpu_ready_b}, 32'd1);
    chk("t4b_rdata", cpu_rdata_b, 32'h11223344);
    chk("t4b_T2_ack", {31'b0, ld_ack_b}, 32'd0);
    cpu_req_b = 0;
    next_cyc(); @(negedge clk);
    chk("t4b_T3_wen", {31'b0, mem_wen_b}, 32'd1);
    chk("t4b_T3_addr", mem_addr_b, 32'h80);
    next_cyc(); @(negedge clk);
    chk("t4b_T4_ack", {31'b0, ld_ack_b}, 32'd1);
    ld_req_b = 0;
    next_cyc();
    chk("t4b_ld_mem", mem_b[6'h20], 32'hDEADBEEF);

    // 5: reset during RMW
    cpu_req = 1; cpu_we = 1; cpu_size = 2'b01; cpu_addr = 32'h40; cpu_wdata = 32'h00005555;
    @(negedge clk);
    chk("t5_T_wen", {31'b0, mem_wen}, 32'd0);
    next_cyc();
    rst = 1; cpu_req = 0;
    @(negedge clk);
    chk("t5_rst_wen", {31'b0, mem_wen}, 32'd0);
    chk("t5_rst_ready", {31'b0, cpu_ready}, 32'd0);
    next_cyc();
    rst = 0;
    @(negedge clk);
    chk("t5_post_ready", {31'b0, cpu_ready}, 32'd0);
    chk("t5_post_ack", {31'b0, ld_ack}, 32'd0);
    chk("t5_post_rdata", cpu_rdata, 32'h0);
    chk("t5_post_wen", {31'b0, mem_wen}, 32'd0);
    chk("t5_post_addr", mem_addr, 32'h0);
    next_cyc(); @(negedge clk);
    chk("t5_late_ready", {31'b0, cpu_ready}, 32'd0);
    chk("t5_mem", mem_a[6'h10], 32'h11223344);
    next_cyc();

    // 6: unaligned word store, request held through RESP
    cpu_req = 1; cpu_we = 1; cpu_size = 2'b11; cpu_addr = 32'h43; cpu_wdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("t6_T_wen", {31'b0, mem_wen}, 32'd1);
    chk("t6_T_idx", {26'b0, mem_addr[7:2]}, 32'h10);
    chk("t6_T_wdata", mem_wdata, 32'hCAFEF00D);
    next_cyc(); @(negedge clk);
    chk("t6_T1_ready", {31'b0, cpu_ready}, 32'd1);
    chk("t6_T1_wen", {31'b0, mem_wen}, 32'd0);
    cpu_we = 0; cpu_size = 2'b10; cpu_addr = 32'h40;
    next_cyc(); @(negedge clk);
    chk("t6_T2_addr", mem_addr, 32'h40);
    chk("t6_T2_ready", {31'b0, cpu_ready}, 32'd0);
    next_cyc(); @(negedge clk);
    chk("t6_T3_ready", {31'b0, cpu_ready}, 32'd0);
    next_cyc(); @(negedge clk);
    chk("t6_T4_ready", {31'b0, cpu_ready}, 32'd1);
    chk("t6_rdata", cpu_rdata, 32'hCAFEF00D);
    cpu_req = 0;
    next_cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
